regfile_mp: RTL

//  Parametrised multi-port integer register file for the next core generation.
//  - Generalises the 32x32 2R1W file: configurable width, depth, read ports and write ports.
//  - Adds optional write-to-read bypass and a per-register busy scoreboard for issue stalls.
//  - Adds a sequential clear engine that zeroes the array one entry per cycle, so no

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_mp_scoreboard.sv | 62 ++++++
 rtl/regfile_mp.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the FSM state encoding and the write-port priority picker.
package regfile_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

    localparam int RF_XLEN  = 32;
    localparam int RF_DEPTH = 32;
    localparam int PRIO_W   = 32;

    // Highest set bit index of m, or -1 when no bit is set.
    function automatic int prio_match(input logic [PRIO_W-1:0] m);
        int idx;
        logic [PRIO_W-1:0] v;
        idx = -1;
        v   = m;
        for (int i = 0; i < PRIO_W; i++) begin
            if (v[0]) idx = i;
            v = v >> 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy bits for issue stalls.
// A new producer (set) beats a retiring one (clear) on the same register.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH   = RF_DEPTH,
    parameter int NR      = 2,
    parameter int NW      = 1,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_clr_all,
    input  logic             i_en,
    input  logic [NW-1:0]    i_wren,
    input  logic [NW*AW-1:0] i_waddr,
    input  logic             i_sb_set,
    input  logic [AW-1:0]    i_sb_addr,
    input  logic [NR*AW-1:0] i_rs_addr,
    output logic [NR-1:0]    o_rs_busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW-1:0]    waddr [NW];
    logic [AW-1:0]    raddr [NR];

    for (genvar k = 0; k < NW; k++) begin : g_wa
        assign waddr[k] = i_waddr[k*AW +: AW];
    end

    // Next busy vector: bulk clear, then retire, then new producer.
    always_comb begin
        busy_d = busy_q;
        if (i_clr_all) begin
            busy_d = '0;
        end else if (i_en) begin
            for (int k = 0; k < NW; k++) begin
                if (i_wren[k]) busy_d[waddr[k]] = 1'b0;
            end
            if (i_sb_set) busy_d[i_sb_addr] = 1'b1;
        end
        if (ZERO_R0 != 0) busy_d[0] = 1'b0;
    end

    // Busy state register; the bulk clear carries the reset.
    always_ff @(posedge i_clk) begin
        busy_q <= busy_d;
    end

    for (genvar j = 0; j < NR; j++) begin : g_rd
        logic [NW-1:0] hit;
        assign raddr[j] = i_rs_addr[j*AW +: AW];
        for (genvar k = 0; k < NW; k++) begin : g_hit
            assign hit[k] = i_wren[k] && (waddr[k] == raddr[j]);
        end
        assign o_rs_busy[j] = i_en && busy_q[raddr[j]] &&
                              !((BYPASS != 0) && (|hit));
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with bypass, busy scoreboard
// and a one-entry-per-cycle clear engine instead of a wide reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN    = RF_XLEN,
    parameter int DEPTH   = RF_DEPTH,
    parameter int NR      = 2,
    parameter int NW      = 1,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    output logic               o_ready,
    input  logic [NW-1:0]      i_rd_wren,
    input  logic [NW*AW-1:0]   i_rd_addr,
    input  logic [NW*XLEN-1:0] i_rd_data,
    input  logic [NR*AW-1:0]   i_rs_addr,
    output logic [NR*XLEN-1:0] o_rs_data,
    output logic [NR-1:0]      o_rs_busy,
    input  logic               i_sb_set,
    input  logic [AW-1:0]      i_sb_addr
);

    rf_state_e         state_q;
    logic [AW-1:0]     ptr_q;
    logic              ready_q;
    logic [XLEN-1:0]   mem_q [DEPTH];

    logic [AW-1:0]     waddr [NW];
    logic [XLEN-1:0]   wdata [NW];
    logic [NW-1:0]     wr_ok;
    logic [AW-1:0]     raddr [NR];

    assign o_ready = ready_q;

    // Writes to x0 are dropped when it is hard-wired.
    for (genvar k = 0; k < NW; k++) begin : g_wp
        assign waddr[k] = i_rd_addr[k*AW +: AW];
        assign wdata[k] = i_rd_data[k*XLEN +: XLEN];
        assign wr_ok[k] = i_rd_wren[k] &&
                          !((ZERO_R0 != 0) && (waddr[k] == '0));
    end

    // Clear engine FSM: walk ptr over the array, then serve traffic.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                RF_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= RF_READY;
                        ready_q <= 1'b1;
                    end
                end
                RF_READY: begin
                    if (i_clr) begin
                        state_q <= RF_CLEAR;
                        ptr_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RF_CLEAR;
                    ptr_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Array update: zero one entry while clearing, else port writes
    // in ascending order so the highest port index wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state_q == RF_CLEAR) begin
                mem_q[ptr_q] <= '0;
            end else begin
                for (int k = 0; k < NW; k++) begin
                    if (wr_ok[k]) mem_q[waddr[k]] <= wdata[k];
                end
            end
        end
    end

    for (genvar j = 0; j < NR; j++) begin : g_rp
        logic [NW-1:0]   hit;
        logic [XLEN-1:0] rd;
        int              sel;

        assign raddr[j] = i_rs_addr[j*AW +: AW];
        for (genvar k = 0; k < NW; k++) begin : g_hit
            assign hit[k] = wr_ok[k] && (waddr[k] == raddr[j]);
        end

        // Read mux: x0, then bypass from the highest matching port.
        always_comb begin
            sel = prio_match(PRIO_W'(hit));
            rd  = '0;
            if (!ready_q) begin
                rd = '0;
            end else if ((ZERO_R0 != 0) && (raddr[j] == '0)) begin
                rd = '0;
            end else begin
                rd = mem_q[raddr[j]];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NW; k++) begin
                        if (sel == k) rd = wdata[k];
                    end
                end
            end
        end

        assign o_rs_data[j*XLEN +: XLEN] = rd;
    end

    rf_scoreboard #(
        .DEPTH   (DEPTH),
        .NR      (NR),
        .NW      (NW),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .i_clk     (i_clk),
        .i_clr_all (i_rst || !ready_q || i_clr),
        .i_en      (ready_q),
        .i_wren    (i_rd_wren),
        .i_waddr   (i_rd_addr),
        .i_sb_set  (i_sb_set),
        .i_sb_addr (i_sb_addr),
        .i_rs_addr (i_rs_addr),
        .o_rs_busy (o_rs_busy)
    );

endmodule
